// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg : shared types and round-robin select function | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axis_arb_pkg;

   localparam int MAX_PORTS    = 16;
   localparam int MAX_ID_WIDTH = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                    found;
      logic [MAX_ID_WIDTH-1:0] idx;
   } rr_sel_t;

   // Scans ptr, ptr+1, ... with wrap at n; the lowest offset that hits wins.
   function automatic rr_sel_t rr_sel(input logic [MAX_PORTS-1:0]    req,
                                      input logic [MAX_ID_WIDTH-1:0] ptr,
                                      input int                      n);
      rr_sel_t r;
      int      k;
      r = '0;
      for (int off = MAX_PORTS - 1; off >= 0; off--) begin
         if (off < n) begin
            k = int'(ptr) + off;
            if (k >= n) k = k - n;
            if (req[MAX_ID_WIDTH'(k)]) begin
               r.found = 1'b1;
               r.idx   = MAX_ID_WIDTH'(k);
            end
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/axis_rr_select.sv
// ---------------------------------------------------------------------------
// axis_rr_select : rotate-and-priority-encode of a request vector | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_rr_select
   import axis_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ID_WIDTH  = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [ID_WIDTH-1:0]  base,
   output logic                 found,
   output logic [ID_WIDTH-1:0]  idx
);

   logic [MAX_PORTS-1:0]    req_ext;
   logic [MAX_ID_WIDTH-1:0] base_ext;
   rr_sel_t                 sel;

   always_comb begin
      req_ext                  = '0;
      req_ext[NUM_PORTS-1:0]   = req;
      base_ext                 = '0;
      base_ext[ID_WIDTH-1:0]   = base;
      sel                      = rr_sel(req_ext, base_ext, NUM_PORTS);
      found                    = sel.found;
      idx                      = ID_WIDTH'(sel.idx);
   end

endmodule

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter : round-robin N:1 AXI-Stream arbiter; AXIS_ARB_PKT_MODE_EN
// holds the grant for whole packets, otherwise beats interleave | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   output logic [$clog2(NUM_PORTS)-1:0]    m_axis_tid,
   input  logic                            m_axis_tready
);

   localparam int ID_WIDTH = $clog2(NUM_PORTS);

`ifdef AXIS_ARB_PKT_MODE_EN
   localparam bit PKT_MODE = 1'b1;
`else
   localparam bit PKT_MODE = 1'b0;
`endif

   arb_state_t            state_q, state_d;
   logic [ID_WIDTH-1:0]   g_q, g_d;
   logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
   logic                  mid_pkt_q, mid_pkt_d;

   logic                  busy;
   logic                  valid_g, last_g;
   logic [DATA_WIDTH-1:0] data_g;
   logic [ID_WIDTH-1:0]   g_plus1, sel_base, sel_idx;
   logic                  sel_found;
   logic                  hs, term;

   // One selector serves both paths: IDLE scans from ptr, a termination from g+1.
   axis_rr_select #(
      .NUM_PORTS (NUM_PORTS),
      .ID_WIDTH  (ID_WIDTH)
   ) u_select (
      .req   (s_axis_tvalid),
      .base  (sel_base),
      .found (sel_found),
      .idx   (sel_idx)
   );

   always_comb begin
      valid_g = 1'b0;
      last_g  = 1'b0;
      data_g  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (g_q == ID_WIDTH'(i)) begin
            valid_g = s_axis_tvalid[i];
            last_g  = s_axis_tlast[i];
            data_g  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      busy          = aresetn && (state_q == ARB_BUSY);
      m_axis_tvalid = busy & valid_g;
      m_axis_tlast  = busy & last_g;
      m_axis_tdata  = busy ? data_g : '0;
      m_axis_tid    = busy ? g_q : '0;
      s_axis_tready = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (busy && (g_q == ID_WIDTH'(i))) s_axis_tready[i] = m_axis_tready;
      end

      g_plus1  = (g_q == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : g_q + 1'b1;
      sel_base = (state_q == ARB_IDLE) ? ptr_q : g_plus1;
      hs       = m_axis_tvalid & m_axis_tready;
      term     = hs & (PKT_MODE ? last_g : 1'b1);
   end

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      ptr_d     = ptr_q;
      mid_pkt_d = mid_pkt_q;
      case (state_q)
         ARB_IDLE: begin
            if (sel_found) begin
               g_d     = sel_idx;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (term) begin
               ptr_d     = g_plus1;
               mid_pkt_d = 1'b0;
               if (sel_found) g_d = sel_idx;
               else           state_d = ARB_IDLE;
            end else if (hs) begin
               mid_pkt_d = 1'b1;
            end else if (!mid_pkt_q && !valid_g) begin
               // Never park the grant on an empty port at a packet boundary.
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= ARB_IDLE;
         g_q       <= '0;
         ptr_q     <= '0;
         mid_pkt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         ptr_q     <= ptr_d;
         mid_pkt_q <= mid_pkt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter : scoreboard bench for axis_rr_arbiter (both modes of
// AXIS_ARB_PKT_MODE_EN) | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axis_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 16;

   logic               aclk = 1'b0;
   logic               aresetn = 1'b0;
   logic [NP*DW-1:0]   s_axis_tdata = '0;
   logic [NP-1:0]      s_axis_tvalid = '0;
   logic [NP-1:0]      s_axis_tlast = '0;
   logic [NP-1:0]      s_axis_tready;
   logic [DW-1:0]      m_axis_tdata;
   logic               m_axis_tvalid;
   logic               m_axis_tlast;
   logic [1:0]         m_axis_tid;
   logic               m_axis_tready = 1'b1;

   axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tready (m_axis_tready)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic          gap;
      logic [DW-1:0] data;
      logic          last;
   } src_beat_t;

   typedef struct {
      logic [1:0]    tid;
      logic [DW-1:0] data;
      logic          last;
   } exp_beat_t;

   src_beat_t  src_q [NP][$];
   exp_beat_t  exp_q [$];
   int         hs_cyc [$];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   logic [NP-1:0] shown_gap = '0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic push_beat(input int p, input logic [DW-1:0] d, input logic l);
      src_beat_t b;
      b.gap = 1'b0; b.data = d; b.last = l;
      src_q[p].push_back(b);
   endtask

   task automatic push_gap(input int p);
      src_beat_t b;
      b.gap = 1'b1; b.data = '0; b.last = 1'b0;
      src_q[p].push_back(b);
   endtask

   task automatic push_exp(input int t, input logic [DW-1:0] d, input logic l);
      exp_beat_t e;
      e.tid = 2'(t); e.data = d; e.last = l;
      exp_q.push_back(e);
   endtask

   function automatic bit src_busy();
      for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   // Upstream sources: one beat per port held until handshaked; gap entries idle one cycle.
   initial begin
      logic [NP-1:0] hs_vec;
      forever begin
         @(negedge aclk);
         hs_vec = s_axis_tvalid & s_axis_tready;
         @(posedge aclk);
         #1;
         for (int i = 0; i < NP; i++) begin
            if (shown_gap[i] || hs_vec[i]) begin
               if (src_q[i].size() != 0) void'(src_q[i].pop_front());
               shown_gap[i] = 1'b0;
            end
            if (src_q[i].size() == 0) begin
               s_axis_tvalid[i] = 1'b0;
               s_axis_tlast[i]  = 1'b0;
            end else if (src_q[i][0].gap) begin
               s_axis_tvalid[i] = 1'b0;
               s_axis_tlast[i]  = 1'b0;
               shown_gap[i]     = 1'b1;
            end else begin
               s_axis_tvalid[i]             = 1'b1;
               s_axis_tlast[i]              = src_q[i][0].last;
               s_axis_tdata[i*DW +: DW]     = src_q[i][0].data;
            end
         end
      end
   end

   // Monitor: every master-side handshake must match the head of the expected queue.
   initial begin
      exp_beat_t e;
      forever begin
         @(negedge aclk);
         if (aresetn && m_axis_tvalid && m_axis_tready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual tid=%0d data=0x%0h last=%0b required no beat",
                        m_axis_tid, m_axis_tdata, m_axis_tlast);
            end else begin
               e = exp_q.pop_front();
               chk("beat", {13'b0, m_axis_tid, m_axis_tdata, m_axis_tlast},
                           {13'b0, e.tid, e.data, e.last});
            end
         end
      end
   end

   task automatic do_reset(input string name);
      @(posedge aclk);
      #2 aresetn = 1'b0;
      @(negedge aclk);
      chk(name, {9'b0, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid}, 32'h0);
      @(posedge aclk);
      #2 aresetn = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 300 && (exp_q.size() != 0 || src_busy()); k++) @(negedge aclk);
      chk({name, "_drain"}, exp_q.size(), 0);
      repeat (3) @(negedge aclk);
   endtask

   initial begin
      int n0;
      repeat (2) @(posedge aclk);
      do_reset("rst_init");

      // Single requester: 1-cycle arbitration latency, then back to IDLE.
      push_beat(2, 16'hA1, 1'b0); push_beat(2, 16'hA2, 1'b0); push_beat(2, 16'hA3, 1'b1);
      push_exp(2, 16'hA1, 1'b0);  push_exp(2, 16'hA2, 1'b0);  push_exp(2, 16'hA3, 1'b1);
      for (int k = 0; k < 20 && !s_axis_tvalid[2]; k++) @(negedge aclk);
      chk("t1_lat_idle", {31'b0, m_axis_tvalid}, 32'h0);
      @(negedge aclk);
      chk("t1_lat_grant", {29'b0, m_axis_tvalid, m_axis_tid}, {29'b0, 1'b1, 2'd2});
      wait_drain("t1");
      chk("t1_idle", {9'b0, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid}, 32'h0);

      // Contention between ports 0, 1, 3 from ptr=0 (reset also clears ptr=3 left by t1).
      do_reset("rst_t2");
      n0 = hs_cyc.size();
      push_beat(0, 16'h10, 1'b0); push_beat(0, 16'h11, 1'b1);
      push_beat(1, 16'h20, 1'b0); push_beat(1, 16'h21, 1'b1);
      push_beat(3, 16'h30, 1'b0); push_beat(3, 16'h31, 1'b1);
`ifdef AXIS_ARB_PKT_MODE_EN
      push_exp(0, 16'h10, 1'b0); push_exp(0, 16'h11, 1'b1);
      push_exp(1, 16'h20, 1'b0); push_exp(1, 16'h21, 1'b1);
      push_exp(3, 16'h30, 1'b0); push_exp(3, 16'h31, 1'b1);
`else
      push_exp(0, 16'h10, 1'b0); push_exp(1, 16'h20, 1'b0); push_exp(3, 16'h30, 1'b0);
      push_exp(0, 16'h11, 1'b1); push_exp(1, 16'h21, 1'b1); push_exp(3, 16'h31, 1'b1);
`endif
      wait_drain("t2");
      if (hs_cyc.size() >= n0 + 6) chk("t2_no_bubble", hs_cyc[n0+5] - hs_cyc[n0], 5);
      else chk("t2_beat_count", hs_cyc.size() - n0, 6);

      // Two ports with 4 beats each.
      do_reset("rst_t3");
      n0 = hs_cyc.size();
      for (int b = 0; b < 4; b++) begin
         push_beat(0, 16'(16'h40 + b), b == 3);
         push_beat(1, 16'(16'h50 + b), b == 3);
      end
`ifdef AXIS_ARB_PKT_MODE_EN
      for (int b = 0; b < 4; b++) push_exp(0, 16'(16'h40 + b), b == 3);
      for (int b = 0; b < 4; b++) push_exp(1, 16'(16'h50 + b), b == 3);
`else
      for (int b = 0; b < 4; b++) begin
         push_exp(0, 16'(16'h40 + b), b == 3);
         push_exp(1, 16'(16'h50 + b), b == 3);
      end
`endif
      wait_drain("t3");
      if (hs_cyc.size() >= n0 + 8) chk("t3_no_bubble", hs_cyc[n0+7] - hs_cyc[n0], 7);
      else chk("t3_beat_count", hs_cyc.size() - n0, 8);

      // Backpressure 1,0,0,1 in the middle of a port-1 packet.
      do_reset("rst_t4");
      push_beat(1, 16'h61, 1'b0); push_beat(1, 16'h62, 1'b0); push_beat(1, 16'h63, 1'b1);
      push_exp(1, 16'h61, 1'b0);  push_exp(1, 16'h62, 1'b0);  push_exp(1, 16'h63, 1'b1);
      for (int k = 0; k < 20 && !m_axis_tvalid; k++) @(negedge aclk);
      chk("t4_ready_hi", {28'b0, s_axis_tready}, 32'h2);
      @(posedge aclk);
      #2 m_axis_tready = 1'b0;
      @(negedge aclk);
      chk("t4_stall1", {9'b0, m_axis_tvalid, m_axis_tid, m_axis_tdata, s_axis_tready},
                       {9'b0, 1'b1, 2'd1, 16'h62, 4'b0000});
      @(negedge aclk);
      chk("t4_stall2", {9'b0, m_axis_tvalid, m_axis_tid, m_axis_tdata, s_axis_tready},
                       {9'b0, 1'b1, 2'd1, 16'h62, 4'b0000});
      @(posedge aclk);
      #2 m_axis_tready = 1'b1;
      @(negedge aclk);
      chk("t4_release", {9'b0, m_axis_tvalid, m_axis_tid, m_axis_tdata, s_axis_tready},
                        {9'b0, 1'b1, 2'd1, 16'h62, 4'b0010});
      wait_drain("t4");

      // Port 1 drops tvalid mid-packet while port 0 starts requesting.
      do_reset("rst_t5");
      push_beat(1, 16'h71, 1'b0); push_gap(1); push_gap(1); push_gap(1); push_beat(1, 16'h72, 1'b1);
      push_gap(0); push_gap(0); push_beat(0, 16'h81, 1'b1);
`ifdef AXIS_ARB_PKT_MODE_EN
      push_exp(1, 16'h71, 1'b0); push_exp(1, 16'h72, 1'b1); push_exp(0, 16'h81, 1'b1);
`else
      push_exp(1, 16'h71, 1'b0); push_exp(0, 16'h81, 1'b1); push_exp(1, 16'h72, 1'b1);
`endif
      wait_drain("t5");

      // Reset during beat 2 of a port-3 packet; restart must scan from ptr=0.
      n0 = hs_cyc.size();
      push_beat(3, 16'h91, 1'b0); push_beat(3, 16'h92, 1'b0); push_beat(3, 16'h93, 1'b1);
      push_exp(3, 16'h91, 1'b0);
      for (int k = 0; k < 50 && hs_cyc.size() <= n0; k++) begin
         @(negedge aclk);
         #1;
      end
      @(posedge aclk);
      #2 aresetn = 1'b0;
      @(negedge aclk);
      chk("t6_rst_outputs", {9'b0, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid}, 32'h0);
      for (int i = 0; i < NP; i++) src_q[i].delete();
      shown_gap = '0;
      @(posedge aclk);
      #2 aresetn = 1'b1;
      push_beat(0, 16'hB0, 1'b1); push_beat(3, 16'hC0, 1'b1);
      push_exp(0, 16'hB0, 1'b1);  push_exp(3, 16'hC0, 1'b1);
      wait_drain("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream AXI-Stream channel between NUM_PORTS upstream requesters.
- Sits in front of the shared stream datapath, for example ahead of a skid buffer or a DMA sink.
- Grants one requester at a time and steers that requester's beats through to the master side.
- Reports the granted source on m_axis_tid.

Parameters:
- NUM_PORTS, 4, number of slave ports (2..16).
- DATA_WIDTH, 16, tdata width per port in bits.
- ID_WIDTH, $clog2(NUM_PORTS), width of m_axis_tid (local parameter).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset: synchronous, active-low; clock aclk.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed per-port data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  granted port's data.
- m_axis_tvalid  out  1  granted port's valid.
- m_axis_tlast  out  1  granted port's last.
- m_axis_tid  out  ID_WIDTH  index of the granted port.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Registered state: fsm (IDLE, BUSY), grant idx g, round-robin pointer ptr, mid_pkt flag.
- Reset (aresetn=0 at a clock edge): fsm=IDLE, g=0, ptr=0, mid_pkt=0.
  - All outputs are forced 0 combinationally while aresetn=0: s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid.
- Selection function sel(req, ptr): first index i with req[i]=1, scanning ptr, ptr+1, ... NUM_PORTS-1, 0, ... ptr-1, with wrap-around.
- IDLE:
  - All s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata, m_axis_tlast, m_axis_tid are 0.
  - If |s_axis_tvalid: g <= sel(s_axis_tvalid, ptr), fsm <= BUSY.
  - Arbitration latency is 1 cycle from first request to m_axis_tvalid.
- BUSY:
  - Datapath is purely combinational with zero latency.
  - m_axis_tvalid = s_axis_tvalid[g]; m_axis_tdata and m_axis_tlast come from port g; m_axis_tid = g.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready = 0.
- Beat handshake: hs = m_axis_tvalid & m_axis_tready.
- Terminating handshake (term): hs and (tlast[g] when packet mode; any hs otherwise). On term:
  - ptr <= (g+1) mod NUM_PORTS; mid_pkt <= 0.
  - Back-to-back re-arbitration in the same cycle with nxt = sel(s_axis_tvalid, (g+1) mod NUM_PORTS).
  - If any request is present: g <= nxt, stay BUSY (no bubble). Otherwise fsm <= IDLE.
- Non-terminating hs: mid_pkt <= 1.
- Lost request: BUSY with mid_pkt=0 and s_axis_tvalid[g]=0 → fsm <= IDLE. Grant is never held on an empty port at a packet boundary.
- Mid-packet stall: BUSY with mid_pkt=1 and s_axis_tvalid[g]=0 → hold the grant. Other ports wait; no interleaving within a packet.
- Simultaneous requests: resolved strictly by the ptr order. The port just served becomes lowest priority, so fairness is bounded: any requesting port is granted within NUM_PORTS terminations.
- Downstream backpressure: m_axis_tready=0 holds everything unchanged, per AXI-S stability rules.
- Reset asserted mid-packet: the packet is truncated at the next edge and the arbiter restarts from ptr=0. Upstream recovery is the system's responsibility.

Optional Feature:
- Macro AXIS_ARB_PKT_MODE_EN.
- Defined: grant is held for a whole packet and terminates only on an hs with tlast.
- Undefined: every beat is a terminating handshake, giving per-beat round-robin interleaving.
  - mid_pkt stays 0.
  - tlast is still forwarded unchanged.

Decomposition:
- Package axis_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  - function rr_sel(req, ptr) returning the index plus a found bit, usable in both the IDLE and term paths.
- One sub-module is natural: axis_rr_select. It is a combinational rotate-and-priority-encode of a NUM_PORTS request vector with a base pointer.

Test Plan:
- Single requester: NUM_PORTS=4, port 2 sends a 3-beat packet 0xA1, 0xA2, 0xA3 (last), m_axis_tready=1 → first m_axis_tvalid one cycle after request, tid=2, beats in order, then IDLE.
- Contention, packet mode: ports 0, 1, 3 each present a 2-beat packet simultaneously, ptr=0 → packets emerge in order tid 0, 1, 3 with no idle cycle between packets and no interleaving.
- Per-beat mode (macro undefined): ports 0 and 1 each hold 4 beats → tid alternates 0, 1, 0, 1, ... every cycle.
- Backpressure: m_axis_tready toggles 1, 0, 0, 1 mid-packet → m_axis_tdata and tid stable while stalled; s_axis_tready[g] mirrors m_axis_tready; no beat is lost or duplicated.
- Mid-packet valid gap: port 1 sends beat 1, drops tvalid for 3 cycles while port 0 requests, then sends last → port 0 is not granted until after port 1's tlast handshake.
- Reset mid-packet: assert aresetn=0 for 1 cycle during beat 2 of a port-3 packet → all outputs 0 during reset; afterwards ptr=0, so a simultaneous request from ports 0 and 3 grants port 0 first.
